// File: rtl/cb_pkg.sv
// Shared constants, result-index names and the streamer state type for the cb operator block.
package cb_pkg;
  localparam int CB_NUM_RES = 9;
  localparam int CB_W       = 4;

  localparam int RES_ARITH  = 0;
  localparam int RES_SHIFT  = 1;
  localparam int RES_REL    = 2;
  localparam int RES_EQ     = 3;
  localparam int RES_BITW   = 4;
  localparam int RES_RED    = 5;
  localparam int RES_LOGIC  = 6;
  localparam int RES_CONCAT = 7;
  localparam int RES_COND   = 8;

  typedef enum logic {IDLE, SEND} cb_stream_state_t;
endpackage

// File: rtl/cb_snapshot_bank.sv
// NUM_RES x W snapshot registers loaded in one cycle; combinational read mux by index.
module cb_snapshot_bank #(
  parameter int NUM_RES = 9,
  parameter int W       = 4,
  parameter int IDX_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NUM_RES*W-1:0] din,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [W-1:0]         rd_data
);
  logic [W-1:0] mem [NUM_RES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RES; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_RES; i++) mem[i] <= din[i*W +: W];
    end
  end

  // Out-of-range indices read as zero; the streamer never consumes them.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = mem[i];
    end
  end
endmodule

// File: rtl/cb_result_streamer.sv
// Snapshots the cb results on cap_req and streams them one word per valid/ready handshake.
// Optional `CB_STREAM_PARITY_EN adds out_par, the registered even-parity bit of out_data.
module cb_result_streamer
  import cb_pkg::*;
#(
  parameter int NUM_RES = CB_NUM_RES,
  parameter int W       = CB_W,
  parameter int IDX_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RES*W-1:0] res_bus,
  input  logic                 cap_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  input  logic                 clr_ovr
`ifdef CB_STREAM_PARITY_EN
  ,
  output logic                 out_par
`endif
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);

  cb_stream_state_t state;
  logic [IDX_W-1:0] idx_nxt;
  logic [W-1:0]     nxt_word;
  logic             load;
  logic             hs;

  assign busy    = (state == SEND);
  assign load    = (state == IDLE) && cap_req;
  assign hs      = out_valid && out_ready;
  assign idx_nxt = out_idx + IDX_W'(1);

  // The bank is read one index ahead so the next word is registered with no bubble.
  cb_snapshot_bank #(
    .NUM_RES (NUM_RES),
    .W       (W),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (res_bus),
    .rd_idx  (idx_nxt),
    .rd_data (nxt_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
`ifdef CB_STREAM_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (busy && cap_req) overrun <= 1'b1;
      else if (clr_ovr)    overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (cap_req) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_data  <= res_bus[W-1:0];
            out_idx   <= '0;
            out_last  <= (NUM_RES == 1);
`ifdef CB_STREAM_PARITY_EN
            out_par   <= ^res_bus[W-1:0];
`endif
          end
        end
        SEND: begin
          if (hs) begin
            if (out_idx == LAST_IDX) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx   <= idx_nxt;
              out_data  <= nxt_word;
              out_last  <= (idx_nxt == LAST_IDX);
`ifdef CB_STREAM_PARITY_EN
              out_par   <= ^nxt_word;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
